// File: rtl/dna_pkg.sv
// Shared constants and types for the device-DNA authentication and report block.
// Frame layout: header, 8 DNA bytes (MSB first), status, XOR checksum of bytes 2..10.
package dna_pkg;

   localparam int DNA_W     = 57;
   localparam int FRAME_LEN = 11;
   localparam int IDX_W     = 4;
   localparam int CNT_W     = 16;

   localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

   // Status byte: {5'b0, dna_timeout, auth_fail, auth_ok}
   localparam int STAT_OK_BIT   = 0;
   localparam int STAT_FAIL_BIT = 1;
   localparam int STAT_TO_BIT   = 2;

   typedef enum logic [1:0] {
      ST_WAIT_DNA = 2'd0,
      ST_CHECK    = 2'd1,
      ST_SEND     = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

endpackage

// File: rtl/dna_frame_mux.sv
// Purely combinational frame byte selector and checksum generator.
// Zero latency; output follows byte_idx, so it holds whenever the index holds.
module dna_frame_mux
   import dna_pkg::*;
#(
   parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE
) (
   input  logic [IDX_W-1:0] byte_idx,
   input  logic [DNA_W-1:0] dna_lat,
   input  logic [7:0]       status,
   output logic [7:0]       frame_byte
);

   logic [63:0] dna_word;
   logic [7:0]  csum;

   assign dna_word = {7'b0, dna_lat};

   always_comb begin
      csum = status;
      for (int i = 0; i < 8; i++) begin
         csum = csum ^ dna_word[8*i +: 8];
      end
   end

   // Index 0 is the header, 1..8 walk the DNA word from its top byte down.
   always_comb begin
      frame_byte = 8'h00;
      if (byte_idx == 4'd0) begin
         frame_byte = HDR_BYTE;
      end else if (byte_idx == 4'd9) begin
         frame_byte = status;
      end else if (byte_idx == 4'd10) begin
         frame_byte = csum;
      end else begin
         for (int k = 1; k <= 8; k++) begin
            if (byte_idx == 4'(k)) begin
               frame_byte = dna_word[8*(8-k) +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dna_auth_report.sv
// Latches device DNA once, compares it with the authorised value and streams an 11-byte report.
// First tx_valid two cycles after dna_valid is sampled; tx_data/index hold until tx_valid&&tx_ready.
module dna_auth_report
   import dna_pkg::*;
#(
   parameter logic [DNA_W-1:0] EXPECTED_DNA   = 57'h123456789ABCDE,
   parameter int unsigned      TIMEOUT_CYCLES = 1024,
   parameter logic [7:0]       HDR_BYTE       = DEF_HDR_BYTE
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [DNA_W-1:0] dna_data,
   input  logic             dna_valid,
   input  logic             report_req,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             auth_ok,
   output logic             auth_fail,
   output logic             dna_timeout,
   output logic             busy
);

   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   state_e             state;
   state_e             state_nxt;
   logic [DNA_W-1:0]   dna_lat;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]   wait_inc;
   logic [IDX_W-1:0]   byte_idx;
   logic               handshake;
   logic               last_byte;
   logic [7:0]         status;
   logic [7:0]         mux_byte;

   assign handshake = (state == ST_SEND) && tx_ready;
   assign last_byte = (byte_idx == IDX_W'(FRAME_LEN - 1));
   assign wait_inc  = wait_cnt + CNT_W'(1);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state <= ST_WAIT_DNA;
      end else begin
         state <= state_nxt;
      end
   end

   // Only DONE listens to report_req, so requests elsewhere are dropped, not queued.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT_DNA: if (dna_valid) state_nxt = ST_CHECK;
         ST_CHECK:    state_nxt = ST_SEND;
         ST_SEND:     if (handshake && last_byte) state_nxt = ST_DONE;
         ST_DONE:     if (report_req) state_nxt = ST_SEND;
         default:     state_nxt = ST_WAIT_DNA;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         dna_lat     <= '0;
         wait_cnt    <= '0;
         dna_timeout <= 1'b0;
         auth_ok     <= 1'b0;
         auth_fail   <= 1'b0;
         byte_idx    <= '0;
      end else begin
         if (state == ST_WAIT_DNA) begin
            // Counter saturates at the limit; a late dna_valid is still latched.
            if (wait_cnt != TO_LIMIT) begin
               wait_cnt <= wait_inc;
               if (wait_inc == TO_LIMIT) begin
                  dna_timeout <= 1'b1;
               end
            end
            if (dna_valid) begin
               dna_lat <= dna_data;
            end
         end

         if (state == ST_CHECK) begin
            auth_ok   <= (dna_lat == EXPECTED_DNA);
            auth_fail <= (dna_lat != EXPECTED_DNA);
         end

         if (handshake) begin
            byte_idx <= last_byte ? '0 : byte_idx + IDX_W'(1);
         end else if ((state == ST_DONE) && report_req) begin
            byte_idx <= '0;
         end
      end
   end

   always_comb begin
      status                = 8'h00;
      status[STAT_OK_BIT]   = auth_ok;
      status[STAT_FAIL_BIT] = auth_fail;
      status[STAT_TO_BIT]   = dna_timeout;
   end

   dna_frame_mux #(
      .HDR_BYTE   (HDR_BYTE)
   ) u_frame_mux (
      .byte_idx   (byte_idx),
      .dna_lat    (dna_lat),
      .status     (status),
      .frame_byte (mux_byte)
   );

   assign tx_valid = (state == ST_SEND);
   assign busy     = (state == ST_SEND);
   assign tx_data  = (state == ST_SEND) ? mux_byte : 8'h00;

endmodule

// File: tb/tb_dna_auth_report.sv
// Scoreboard bench for dna_auth_report: expected frame bytes are queued at stimulus time
// and popped on every tx handshake observed on the falling edge.
module tb_dna_auth_report;

   localparam logic [56:0] DNA_MATCH = 57'h123456789ABCDE;
   localparam logic [56:0] DNA_BAD   = 57'h123456789ABCDF;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [56:0] dna_data;
   logic        dna_valid;
   logic        report_req;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        auth_ok;
   logic        auth_fail;
   logic        dna_timeout;
   logic        busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          hs_cnt   = 0;
   int          rdy_mode = 0;
   int          cyc;
   logic [7:0]  exp_q[$];
   logic        stall_prev = 1'b0;
   logic [7:0]  held_byte  = 8'h00;
   logic [7:0]  golden[11] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                               8'h9A, 8'hBC, 8'hDE, 8'h01, 8'hF1};

   always #5 sys_clk = ~sys_clk;

   dna_auth_report #(
      .EXPECTED_DNA   (DNA_MATCH),
      .TIMEOUT_CYCLES (8),
      .HDR_BYTE       (8'hA5)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .dna_data    (dna_data),
      .dna_valid   (dna_valid),
      .report_req  (report_req),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .auth_ok     (auth_ok),
      .auth_fail   (auth_fail),
      .dna_timeout (dna_timeout),
      .busy        (busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic push_golden();
      for (int i = 0; i < 11; i++) exp_q.push_back(golden[i]);
   endtask

   // Reference frame built directly from the frame definition.
   task automatic push_frame(input logic [56:0] d, input logic ok, input logic fail, input logic to);
      logic [63:0] w;
      logic [7:0]  st;
      logic [7:0]  cs;
      logic [7:0]  b;
      w  = {7'b0, d};
      st = {5'b0, to, fail, ok};
      cs = st;
      exp_q.push_back(8'hA5);
      for (int k = 0; k < 8; k++) begin
         b  = w[63-8*k -: 8];
         cs = cs ^ b;
         exp_q.push_back(b);
      end
      exp_q.push_back(st);
      exp_q.push_back(cs);
   endtask

   task automatic pulse_req();
      report_req = 1'b1;
      tick();
      report_req = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      exp_q.delete();
      tick();
      tick();
      sys_rst = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input int budget, output int n);
      n = 0;
      while ((exp_q.size() != 0 || tx_valid) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_idle"}, tx_valid, 0);
   endtask

   // tx_ready driver: mode 0 always ready, mode 1 repeats 1,0,0,1.
   initial begin
      logic [3:0] pat;
      int ph;
      pat = 4'b1001;
      ph  = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         if (rdy_mode == 0) begin
            tx_ready = 1'b1;
         end else begin
            tx_ready = pat[ph];
            ph = (ph + 1) % 4;
         end
      end
   end

   // Monitor: handshakes pop the scoreboard; stalled bytes must not move.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (!sys_rst && tx_valid) begin
            if (stall_prev) check("stall_hold", tx_data, held_byte);
            if (tx_ready) begin
               hs_cnt++;
               stall_prev = 1'b0;
               if (exp_q.size() == 0) check("unexpected_byte", exp_q.size(), 1);
               else check("frame_byte", tx_data, exp_q.pop_front());
            end else begin
               stall_prev = 1'b1;
               held_byte  = tx_data;
            end
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      sys_rst    = 1'b1;
      dna_data   = '0;
      dna_valid  = 1'b0;
      report_req = 1'b0;
      tick();
      tick();
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_busy", busy, 0);
      check("rst_auth_ok", auth_ok, 0);
      check("rst_auth_fail", auth_fail, 0);
      check("rst_timeout", dna_timeout, 0);

      // Matching DNA, latency and full-rate throughput
      sys_rst = 1'b0;
      tick();
      report_req = 1'b1;
      tick();
      report_req = 1'b0;
      dna_data  = DNA_MATCH;
      dna_valid = 1'b1;
      push_golden();
      tick();
      check("lat_check_cycle", tx_valid, 0);
      tick();
      check("lat_first_valid", tx_valid, 1);
      check("busy_in_send", busy, 1);
      wait_frame("match", 40, cyc);
      check("match_cycles", cyc, 11);
      check("match_auth_ok", auth_ok, 1);
      check("match_auth_fail", auth_fail, 0);
      check("match_timeout", dna_timeout, 0);
      check("done_busy", busy, 0);

      // Retransmit from DONE; a request during SEND is dropped
      push_frame(DNA_MATCH, 1'b1, 1'b0, 1'b0);
      pulse_req();
      tick();
      tick();
      check("retx_busy", busy, 1);
      pulse_req();
      wait_frame("retx", 40, cyc);
      repeat (4) tick();
      check("req_not_queued", tx_valid, 0);

      // Backpressure 1,0,0,1
      rdy_mode = 1;
      push_frame(DNA_MATCH, 1'b1, 1'b0, 1'b0);
      pulse_req();
      wait_frame("bp", 100, cyc);
      rdy_mode = 0;

      // Mismatching DNA
      dna_valid = 1'b0;
      do_reset();
      dna_data  = DNA_BAD;
      dna_valid = 1'b1;
      push_frame(DNA_BAD, 1'b0, 1'b1, 1'b0);
      wait_frame("bad", 40, cyc);
      check("bad_auth_ok", auth_ok, 0);
      check("bad_auth_fail", auth_fail, 1);

      // Reset mid-frame at byte 5, then a fresh capture and frame
      dna_valid = 1'b0;
      do_reset();
      dna_data  = DNA_MATCH;
      dna_valid = 1'b1;
      hs_cnt    = 0;
      push_golden();
      cyc = 0;
      while (hs_cnt < 4 && cyc < 50) begin
         tick();
         cyc++;
      end
      check("mid_reach_byte5", hs_cnt, 4);
      check("mid_byte5_data", tx_data, 8'h56);
      sys_rst = 1'b1;
      exp_q.delete();
      tick();
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_tx_data", tx_data, 0);
      check("mid_rst_auth_ok", auth_ok, 0);
      check("mid_rst_auth_fail", auth_fail, 0);
      sys_rst = 1'b0;
      push_golden();
      wait_frame("post_rst", 40, cyc);

      // Timeout at 8 cycles, DNA arrives at cycle 20
      dna_valid = 1'b0;
      do_reset();
      repeat (7) tick();
      check("to_before_limit", dna_timeout, 0);
      tick();
      check("to_at_limit", dna_timeout, 1);
      repeat (12) tick();
      check("to_still_waiting", tx_valid, 0);
      dna_data  = DNA_MATCH;
      dna_valid = 1'b1;
      push_frame(DNA_MATCH, 1'b1, 1'b0, 1'b1);
      wait_frame("to", 40, cyc);
      check("to_sticky", dna_timeout, 1);
      check("to_auth_ok", auth_ok, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
